// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM state encoding and parity mode constants for the UART transmitter.
package uart_tx_pkg;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period counter pulsing bit_done on the last cycle of each bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt;
    assign bit_done = cnt == CW'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk) begin
        if (rst || clr || bit_done) cnt <= '0;
        else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: transmit-only UART serializer (start, LSB-first data, optional parity, stop bits).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_W       = 6,
    parameter int CLKS_PER_BIT = 100,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [DATA_W-1:0] in_mem,
    input  logic              in_utx_st,
    output logic              out_rx,
    output logic              out_utx_bs
);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    state_t state, state_n;
    logic [DATA_W-1:0] sh, sh_n;
    logic [BW-1:0] bit_cnt, bit_cnt_n;
    logic par, par_n, rx_n, load, bit_done;
    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk(in_clk),
        .rst(in_rst),
        .clr(load),
        .bit_done(bit_done)
    );
    always_comb begin
        state_n   = state;
        sh_n      = sh;
        bit_cnt_n = bit_cnt;
        par_n     = par;
        load      = 1'b0;
        case (state)
            S_IDLE:   load = in_utx_st;
            S_START:  if (bit_done) begin
                state_n   = S_DATA;
                bit_cnt_n = '0;
            end
            S_DATA:   if (bit_done) begin
                sh_n      = sh >> 1;
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == LAST_DATA) begin
                    state_n   = PARITY != PAR_NONE ? S_PARITY : S_STOP;
                    bit_cnt_n = '0;
                end
            end
            S_PARITY: if (bit_done) state_n = S_STOP;
            S_STOP:   if (bit_done) begin
                bit_cnt_n = bit_cnt + 1'b1;
                if (bit_cnt == LAST_STOP) begin
                    state_n   = S_IDLE;
                    bit_cnt_n = '0;
                    load      = in_utx_st;
                end
            end
            default:  state_n = S_IDLE;
        endcase
        // Acceptance at the end of the last stop bit chains frames with no idle gap.
        if (load) begin
            state_n   = S_START;
            sh_n      = in_mem;
            par_n     = ^in_mem ^ (PARITY == PAR_ODD);
            bit_cnt_n = '0;
        end
        rx_n = state_n == S_START  ? 1'b0 :
               state_n == S_DATA   ? sh_n[0] :
               state_n == S_PARITY ? par_n : 1'b1;
    end
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state      <= S_IDLE;
            sh         <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
            out_rx     <= 1'b1;
            out_utx_bs <= 1'b0;
        end else begin
            state      <= state_n;
            sh         <= sh_n;
            bit_cnt    <= bit_cnt_n;
            par        <= par_n;
            out_rx     <= rx_n;
            out_utx_bs <= state_n != S_IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx across parity modes and bit periods.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [5:0] mem = '0;
    logic st [4];
    logic rx [4];
    logic bs [4];
    int checks = 0;
    int errors = 0;
    bit exp_q [$];

    always #5 clk = ~clk;

    uart_tx #(.DATA_W(6), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) dut0 (
        .in_clk(clk), .in_rst(rst), .in_mem(mem), .in_utx_st(st[0]), .out_rx(rx[0]), .out_utx_bs(bs[0]));
    uart_tx #(.DATA_W(6), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) dut1 (
        .in_clk(clk), .in_rst(rst), .in_mem(mem), .in_utx_st(st[1]), .out_rx(rx[1]), .out_utx_bs(bs[1]));
    uart_tx #(.DATA_W(6), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut2 (
        .in_clk(clk), .in_rst(rst), .in_mem(mem), .in_utx_st(st[2]), .out_rx(rx[2]), .out_utx_bs(bs[2]));
    uart_tx #(.DATA_W(6), .CLKS_PER_BIT(100), .PARITY(0), .STOP_BITS(1)) dut3 (
        .in_clk(clk), .in_rst(rst), .in_mem(mem), .in_utx_st(st[3]), .out_rx(rx[3]), .out_utx_bs(bs[3]));

    task automatic push_frame(input logic [5:0] d, input int par);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 6; i++) exp_q.push_back(d[i]);
        if (par != 0) exp_q.push_back((^d) ^ (par == 2));
        exp_q.push_back(1'b1);
    endtask

    task automatic start(input int sel, input logic [5:0] d, input bit hold);
        mem = d;
        st[sel] = 1'b1;
        @(negedge clk);
        if (!hold) st[sel] = 1'b0;
    endtask

    task automatic capture(input int sel, input int cpb, input int nbits, input int chg_at,
                           input logic chg_st, input logic [5:0] chg_mem);
        bit busy_bad = 0;
        for (int b = 0; b < nbits; b++) begin
            bit e = 1'b1;
            bit bad = 0;
            logic got = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty dut%0d bit%0d", sel, b);
            end else e = exp_q.pop_front();
            for (int c = 0; c < cpb; c++) begin
                int idx = b * cpb + c;
                if (idx > 0) @(negedge clk);
                if (idx == chg_at) begin
                    st[sel] = chg_st;
                    mem = chg_mem;
                end
                if (idx == chg_at + 1) st[sel] = 1'b0;
                if (rx[sel] !== e) begin
                    bad = 1;
                    got = rx[sel];
                end
                if (bs[sel] !== 1'b1) busy_bad = 1;
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL frame_bit dut%0d bit%0d: got %b expected %b", sel, b, got, e);
            end
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL busy_window dut%0d: busy dropped within %0d cycles", sel, nbits * cpb);
        end
    endtask

    task automatic expect_idle(input int sel, input int n);
        bit bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rx[sel] !== 1'b1 || bs[sel] !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL idle dut%0d: rx=%b busy=%b expected rx=1 busy=0", sel, rx[sel], bs[sel]);
        end
    endtask

    task automatic check_q_empty(input int sel);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left dut%0d: %0d bits left expected 0", sel, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        st[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rx[0] !== 1'b1 || bs[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_out: rx=%b busy=%b expected rx=1 busy=0", rx[0], bs[0]);
            end
        end
        rst = 1'b0;
        st[0] = 1'b0;
        for (int s = 0; s < 4; s++) expect_idle(s, 2);
        expect_idle(0, 8);
    endtask

    task automatic test_basic;
        start(0, 6'b101010, 0);
        push_frame(6'b101010, 0);
        capture(0, 4, 8, -1, 1'b0, 6'b101010);
        expect_idle(0, 6);
        check_q_empty(0);
    endtask

    task automatic test_parity;
        start(1, 6'b101010, 0);
        push_frame(6'b101010, 1);
        capture(1, 4, 9, -1, 1'b0, 6'b101010);
        expect_idle(1, 4);
        check_q_empty(1);
        start(2, 6'b101010, 0);
        push_frame(6'b101010, 2);
        capture(2, 4, 9, -1, 1'b0, 6'b101010);
        expect_idle(2, 4);
        check_q_empty(2);
        start(1, 6'b110100, 0);
        push_frame(6'b110100, 1);
        capture(1, 4, 9, -1, 1'b0, 6'b110100);
        expect_idle(1, 4);
        check_q_empty(1);
    endtask

    task automatic test_busy_ignore;
        start(0, 6'b101010, 0);
        push_frame(6'b101010, 0);
        capture(0, 4, 8, 10, 1'b1, 6'b111111);
        expect_idle(0, 12);
        check_q_empty(0);
    endtask

    task automatic test_back_to_back;
        start(0, 6'b000001, 1);
        repeat (3) push_frame(6'b000001, 0);
        capture(0, 4, 24, 70, 1'b0, 6'b000001);
        expect_idle(0, 8);
        check_q_empty(0);
    endtask

    task automatic test_reset_mid;
        start(0, 6'b101010, 0);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rx[0] !== 1'b1 || bs[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: rx=%b busy=%b expected rx=1 busy=0", rx[0], bs[0]);
        end
        rst = 1'b0;
        expect_idle(0, 3);
        start(0, 6'b011001, 0);
        push_frame(6'b011001, 0);
        capture(0, 4, 8, -1, 1'b0, 6'b011001);
        expect_idle(0, 4);
        check_q_empty(0);
    endtask

    task automatic test_timing;
        checks++;
        if (rx[3] !== 1'b1) begin
            errors++;
            $display("FAIL slow_pre_start: rx=%b expected 1", rx[3]);
        end
        start(3, 6'b101010, 0);
        push_frame(6'b101010, 0);
        capture(3, 100, 8, -1, 1'b0, 6'b101010);
        expect_idle(3, 4);
        check_q_empty(3);
    endtask

    initial begin
        for (int s = 0; s < 4; s++) st[s] = 1'b0;
        test_reset;
        test_basic;
        test_parity;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid;
        test_timing;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
